// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges a fixed-latency ALU result and a FIFO-buffered
// load-return stream onto the single register-file write port, and keeps a
// per-register pending-load scoreboard that the issue stage uses to stall.
module writeback_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        alu_valid_i,
    input  logic [4:0]  alu_rd_i,
    input  logic [31:0] alu_data_i,
    output logic        alu_stall_o,
    input  logic        ld_valid_i,
    output logic        ld_ready_o,
    input  logic [4:0]  ld_rd_i,
    input  logic [31:0] ld_data_i,
    input  logic        issue_ld_i,
    input  logic [4:0]  issue_rd_i,
    input  logic [4:0]  Rs1_i,
    input  logic [4:0]  Rs2_i,
    output logic        Rs1Busy_o,
    output logic        Rs2Busy_o,
    output logic        RegWrite_o,
    output logic [4:0]  RdW_o,
    output logic [31:0] WD_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    // Load-return FIFO storage; the head is read combinationally so a pop
    // can drive the registered write port in the same cycle it is selected.
    logic [4:0]    fifo_rd_mem   [DEPTH];
    logic [31:0]   fifo_data_mem [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [31:0]   pending_q, pending_d;
    logic          regwrite_q, regwrite_d;
    logic [4:0]    rdw_q, rdw_d;
    logic [31:0]   wd_q, wd_d;

    logic          fifo_empty;
    logic          force_pop;
    logic          pop;
    logic          push;
    logic          alu_write;
    logic [4:0]    head_rd;
    logic [31:0]   head_data;

    assign fifo_empty = (count_q == '0);
    assign force_pop  = !fifo_empty && (starve_q == SW'(STARVE_LIMIT));
    assign ld_ready_o = (count_q != CW'(DEPTH));
    // rd==0 loads complete the handshake but are dropped instead of enqueued.
    assign push       = ld_valid_i && ld_ready_o && (ld_rd_i != 5'd0);
    assign head_rd    = fifo_rd_mem[rd_ptr_q];
    assign head_data  = fifo_data_mem[rd_ptr_q];
    assign Rs1Busy_o  = pending_q[Rs1_i];
    assign Rs2Busy_o  = pending_q[Rs2_i];
    assign RegWrite_o = regwrite_q;
    assign RdW_o      = rdw_q;
    assign WD_o       = wd_q;

    // Source selection: a starved FIFO head beats the ALU, otherwise ALU first.
    always_comb begin
        pop         = 1'b0;
        alu_write   = 1'b0;
        alu_stall_o = 1'b0;
        if (force_pop) begin
            pop         = 1'b1;
            alu_stall_o = alu_valid_i;
        end else if (alu_valid_i && (alu_rd_i != 5'd0)) begin
            alu_write = 1'b1;
        end else if (!fifo_empty) begin
            pop = 1'b1;
        end
    end

    // Next-state for pointers, occupancy, starvation counter, scoreboard and write port.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        starve_d   = starve_q;
        pending_d  = pending_q;
        regwrite_d = 1'b0;
        rdw_d      = rdw_q;
        wd_d       = wd_q;

        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (fifo_empty || pop)
            starve_d = '0;
        else if (starve_q != SW'(STARVE_LIMIT))
            starve_d = starve_q + SW'(1);

        // Clear on the popping write first so a same-cycle issue to that rd wins.
        if (pop) pending_d[head_rd] = 1'b0;
        if (issue_ld_i && (issue_rd_i != 5'd0)) pending_d[issue_rd_i] = 1'b1;
        pending_d[0] = 1'b0;

        if (pop) begin
            regwrite_d = 1'b1;
            rdw_d      = head_rd;
            wd_d       = head_data;
        end else if (alu_write) begin
            regwrite_d = 1'b1;
            rdw_d      = alu_rd_i;
            wd_d       = alu_data_i;
        end
    end

    // Control and output state; reset discards queued loads by clearing pointers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            starve_q   <= '0;
            pending_q  <= '0;
            regwrite_q <= 1'b0;
            rdw_q      <= 5'd0;
            wd_q       <= 32'd0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            starve_q   <= starve_d;
            pending_q  <= pending_d;
            regwrite_q <= regwrite_d;
            rdw_q      <= rdw_d;
            wd_q       <= wd_d;
        end
    end

    // FIFO payload write; contents need no reset since pointers gate validity.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_rd_mem[wr_ptr_q]   <= ld_rd_i;
            fifo_data_mem[wr_ptr_q] <= ld_data_i;
        end
    end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed testbench for writeback_arbiter with hand-computed expectations.
module tb_writeback_arbiter;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        alu_valid_i;
    logic [4:0]  alu_rd_i;
    logic [31:0] alu_data_i;
    logic        alu_stall_o;
    logic        ld_valid_i;
    logic        ld_ready_o;
    logic [4:0]  ld_rd_i;
    logic [31:0] ld_data_i;
    logic        issue_ld_i;
    logic [4:0]  issue_rd_i;
    logic [4:0]  Rs1_i;
    logic [4:0]  Rs2_i;
    logic        Rs1Busy_o;
    logic        Rs2Busy_o;
    logic        RegWrite_o;
    logic [4:0]  RdW_o;
    logic [31:0] WD_o;

    int n_vec = 0;
    int n_err = 0;

    writeback_arbiter #(.DEPTH(4), .STARVE_LIMIT(3)) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .alu_valid_i (alu_valid_i),
        .alu_rd_i    (alu_rd_i),
        .alu_data_i  (alu_data_i),
        .alu_stall_o (alu_stall_o),
        .ld_valid_i  (ld_valid_i),
        .ld_ready_o  (ld_ready_o),
        .ld_rd_i     (ld_rd_i),
        .ld_data_i   (ld_data_i),
        .issue_ld_i  (issue_ld_i),
        .issue_rd_i  (issue_rd_i),
        .Rs1_i       (Rs1_i),
        .Rs2_i       (Rs2_i),
        .Rs1Busy_o   (Rs1Busy_o),
        .Rs2Busy_o   (Rs2Busy_o),
        .RegWrite_o  (RegWrite_o),
        .RdW_o       (RdW_o),
        .WD_o        (WD_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle();
        alu_valid_i = 1'b0; alu_rd_i = 5'd0; alu_data_i = 32'd0;
        ld_valid_i  = 1'b0; ld_rd_i  = 5'd0; ld_data_i  = 32'd0;
        issue_ld_i  = 1'b0; issue_rd_i = 5'd0;
    endtask

    task automatic alu(input logic [4:0] rd, input logic [31:0] d);
        alu_valid_i = 1'b1; alu_rd_i = rd; alu_data_i = d;
    endtask

    task automatic ld(input logic [4:0] rd, input logic [31:0] d);
        ld_valid_i = 1'b1; ld_rd_i = rd; ld_data_i = d;
    endtask

    // Advance one clock and sample 1 time unit after the edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
        if (RegWrite_o) $display("t=%0t write rd=%0d data=0x%08h", $time, RdW_o, WD_o);
    endtask

    // Check the write port after the edge that selected a source.
    task automatic exp_wr(input string tag, input logic [4:0] rd, input logic [31:0] d);
        chk({tag, ".we"}, 32'(RegWrite_o), 32'd1);
        chk({tag, ".rd"}, 32'(RdW_o), 32'(rd));
        chk({tag, ".wd"}, WD_o, d);
    endtask

    initial begin
        idle();
        Rs1_i = 5'd0; Rs2_i = 5'd0;
        reset_i = 1'b1;
        tick(); tick();
        chk("rst.we", 32'(RegWrite_o), 32'd0);
        chk("rst.rd", 32'(RdW_o), 32'd0);
        chk("rst.wd", WD_o, 32'd0);
        chk("rst.ready", 32'(ld_ready_o), 32'd1);
        reset_i = 1'b0;

        // 1: single ALU write, one-cycle pulse
        alu(5'd5, 32'hDEADBEEF);
        #1 chk("t1.stall", 32'(alu_stall_o), 32'd0);
        tick(); idle();
        exp_wr("t1", 5'd5, 32'hDEADBEEF);
        tick();
        chk("t1.we_off", 32'(RegWrite_o), 32'd0);

        // 2: issued load tracked by scoreboard until its write
        Rs1_i = 5'd7; issue_ld_i = 1'b1; issue_rd_i = 5'd7;
        #1 chk("t2.nofwd", 32'(Rs1Busy_o), 32'd0);
        tick(); idle();
        chk("t2.busy", 32'(Rs1Busy_o), 32'd1);
        tick();
        chk("t2.busy2", 32'(Rs1Busy_o), 32'd1);
        ld(5'd7, 32'h1234);
        #1 chk("t2.ready", 32'(ld_ready_o), 32'd1);
        tick(); idle();
        chk("t2.nobypass", 32'(RegWrite_o), 32'd0);
        chk("t2.busy3", 32'(Rs1Busy_o), 32'd1);
        tick();
        exp_wr("t2", 5'd7, 32'h1234);
        tick();
        chk("t2.cleared", 32'(Rs1Busy_o), 32'd0);
        chk("t2.we_off", 32'(RegWrite_o), 32'd0);

        // 3: fill FIFO behind a busy ALU, starvation pop, refill, in-order drain
        Rs1_i = 5'd0;
        for (int i = 0; i < 4; i++) begin
            alu(5'd1, 32'h100 + 32'(i));
            ld(5'(10 + i), 32'hA0 + 32'(i));
            tick();
            exp_wr($sformatf("t3.alu%0d", i), 5'd1, 32'h100 + 32'(i));
        end
        alu(5'd1, 32'h104);
        ld(5'd14, 32'hA4);
        #1 chk("t3.full", 32'(ld_ready_o), 32'd0);
        chk("t3.stall", 32'(alu_stall_o), 32'd1);
        tick();
        exp_wr("t3.force", 5'd10, 32'hA0);
        chk("t3.ready_back", 32'(ld_ready_o), 32'd1);
        chk("t3.stall_off", 32'(alu_stall_o), 32'd0);
        tick(); idle();
        exp_wr("t3.alu_held", 5'd1, 32'h104);
        for (int i = 1; i < 5; i++) begin
            tick();
            exp_wr($sformatf("t3.pop%0d", i), 5'(10 + i), 32'hA0 + 32'(i));
        end
        tick();
        chk("t3.drained", 32'(RegWrite_o), 32'd0);

        // 4: one queued load vs continuous ALU
        alu(5'd2, 32'h200);
        ld(5'd20, 32'hB0);
        tick();
        ld_valid_i = 1'b0; ld_rd_i = 5'd0;
        exp_wr("t4.alu0", 5'd2, 32'h200);
        for (int i = 1; i < 4; i++) begin
            alu(5'd2, 32'h200 + 32'(i));
            #1 chk($sformatf("t4.nostall%0d", i), 32'(alu_stall_o), 32'd0);
            tick();
            exp_wr($sformatf("t4.alu%0d", i), 5'd2, 32'h200 + 32'(i));
        end
        alu(5'd2, 32'h204);
        #1 chk("t4.stall", 32'(alu_stall_o), 32'd1);
        tick();
        exp_wr("t4.load", 5'd20, 32'hB0);
        chk("t4.stall_off", 32'(alu_stall_o), 32'd0);
        tick(); idle();
        exp_wr("t4.alu_held", 5'd2, 32'h204);
        tick();
        chk("t4.we_off", 32'(RegWrite_o), 32'd0);

        // 5: x0 destinations never write, enqueue or mark busy
        alu(5'd0, 32'h55);
        ld(5'd0, 32'h66);
        issue_ld_i = 1'b1; issue_rd_i = 5'd0;
        Rs1_i = 5'd0;
        #1 chk("t5.stall", 32'(alu_stall_o), 32'd0);
        tick(); idle();
        chk("t5.we0", 32'(RegWrite_o), 32'd0);
        chk("t5.busy", 32'(Rs1Busy_o), 32'd0);
        tick();
        chk("t5.we1", 32'(RegWrite_o), 32'd0);

        // 6: reset discards queued loads and scoreboard
        Rs1_i = 5'd3; Rs2_i = 5'd4;
        issue_ld_i = 1'b1; issue_rd_i = 5'd3;
        tick();
        issue_rd_i = 5'd4;
        tick(); idle();
        alu(5'd9, 32'h900); ld(5'd3, 32'hC3);
        tick();
        alu(5'd9, 32'h901); ld(5'd4, 32'hC4);
        tick(); idle();
        chk("t6.busy1", 32'(Rs1Busy_o), 32'd1);
        chk("t6.busy2", 32'(Rs2Busy_o), 32'd1);
        chk("t6.we_pre", 32'(RegWrite_o), 32'd1);
        reset_i = 1'b1;
        #1;
        chk("t6.we", 32'(RegWrite_o), 32'd0);
        chk("t6.ready", 32'(ld_ready_o), 32'd1);
        chk("t6.rs1", 32'(Rs1Busy_o), 32'd0);
        chk("t6.rs2", 32'(Rs2Busy_o), 32'd0);
        tick();
        reset_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("t6.nowr%0d", i), 32'(RegWrite_o), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
